// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory request/response port between the
// instruction-fetch requester (imem_*) and the load/store requester (dmem_*).
// One transaction is outstanding at a time, and each response returns to the
// requester that owns it.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where both valid and ready are 1. A valid request holds its payload until
// that edge. Ready may depend combinationally on valid.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin priority between the
// two requesters. Without it, dmem always wins when both are valid.
//
// state_dbg exposes the FSM state (0 = IDLE, 1 = WAIT_RESP).
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              imem_req_valid,
    output logic              imem_req_ready,
    input  logic [ADDR_W-1:0] imem_req_addr,
    output logic              imem_resp_valid,
    input  logic              imem_resp_ready,
    output logic [DATA_W-1:0] imem_resp_data,
    input  logic              dmem_req_valid,
    output logic              dmem_req_ready,
    input  logic [ADDR_W-1:0] dmem_req_addr,
    input  logic              dmem_req_we,
    input  logic [DATA_W-1:0] dmem_req_wdata,
    input  logic [STRB_W-1:0] dmem_req_wstrb,
    output logic              dmem_resp_valid,
    input  logic              dmem_resp_ready,
    output logic [DATA_W-1:0] dmem_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              busy,
    output logic              state_dbg
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } state_t;

    state_t state;
    logic   owner;      // 0 = imem, 1 = dmem
    logic   dmem_prio;  // dmem wins a tie
    logic   sel_dmem;   // requester currently selected in IDLE

`ifdef MEM_ARB_RR_EN
    logic rr_last;      // owner of the most recently accepted request

    // The requester that did not win last time wins a tie.
    assign dmem_prio = (rr_last == 1'b0);
`else
    assign dmem_prio = 1'b1;
`endif

    assign sel_dmem = dmem_req_valid & (~imem_req_valid | dmem_prio);

    // Payload mux: imem requests are always reads with no data or strobes.
    always_comb begin
        mem_req_addr  = imem_req_addr;
        mem_req_we    = 1'b0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;
        if (sel_dmem) begin
            mem_req_addr  = dmem_req_addr;
            mem_req_we    = dmem_req_we;
            mem_req_wdata = dmem_req_wdata;
            mem_req_wstrb = dmem_req_wstrb;
        end
    end

    // Response data goes to both sides; only the owner sees resp_valid.
    assign imem_resp_data  = mem_resp_rdata;
    assign dmem_resp_rdata = mem_resp_rdata;

    assign busy      = (state == WAIT_RESP);
    assign state_dbg = state;

    // Handshake routing from state; all valid/ready outputs are held low in reset.
    always_comb begin
        mem_req_valid   = 1'b0;
        imem_req_ready  = 1'b0;
        dmem_req_ready  = 1'b0;
        mem_resp_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        dmem_resp_valid = 1'b0;
        if (reset_n) begin
            if (state == IDLE) begin
                if (sel_dmem) begin
                    mem_req_valid  = dmem_req_valid;
                    dmem_req_ready = mem_req_ready;
                end else begin
                    mem_req_valid  = imem_req_valid;
                    imem_req_ready = mem_req_ready;
                end
            end else begin
                if (owner) begin
                    dmem_resp_valid = mem_resp_valid;
                    mem_resp_ready  = dmem_resp_ready;
                end else begin
                    imem_resp_valid = mem_resp_valid;
                    mem_resp_ready  = imem_resp_ready;
                end
            end
        end
    end

    // FSM: latch the owner on request fire, return to IDLE on response fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_last <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_valid && mem_req_ready) begin
                        state   <= WAIT_RESP;
                        owner   <= sel_dmem;
`ifdef MEM_ARB_RR_EN
                        rr_last <= sel_dmem;
`endif
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid && mem_resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A table of per-cycle
// vectors covers the main request/response sequences; hand-written sequences
// cover reset mid-transaction, response back-pressure and round-robin.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic        dmem_resp_ready;
    logic [31:0] dmem_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        busy;
    logic        state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_data  (imem_resp_data),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_ready (dmem_resp_ready),
        .dmem_resp_rdata (dmem_resp_rdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_we      (mem_req_we),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_wstrb   (mem_req_wstrb),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_ready  (mem_resp_ready),
        .mem_resp_rdata  (mem_resp_rdata),
        .busy            (busy),
        .state_dbg       (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        // inputs
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dws;
        logic        mqr;
        logic        msv;
        logic [31:0] mrd;
        logic        irr;
        logic        drr;
        // expected outputs
        logic        e_mqv;
        logic [31:0] e_ma;
        logic        e_mwe;
        logic [31:0] e_mwd;
        logic [3:0]  e_mws;
        logic        e_ird;
        logic        e_drd;
        logic        e_irv;
        logic        e_drv;
        logic        e_mrr;
        logic        e_busy;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_req_valid  = 1'b0;
        imem_req_addr   = '0;
        imem_resp_ready = 1'b0;
        dmem_req_valid  = 1'b0;
        dmem_req_addr   = '0;
        dmem_req_we     = 1'b0;
        dmem_req_wdata  = '0;
        dmem_req_wstrb  = '0;
        dmem_resp_ready = 1'b0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_rdata  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int i);
        imem_req_valid  = vecs[i].iv;
        imem_req_addr   = vecs[i].ia;
        dmem_req_valid  = vecs[i].dv;
        dmem_req_we     = vecs[i].dwe;
        dmem_req_addr   = vecs[i].da;
        dmem_req_wdata  = vecs[i].dwd;
        dmem_req_wstrb  = vecs[i].dws;
        mem_req_ready   = vecs[i].mqr;
        mem_resp_valid  = vecs[i].msv;
        mem_resp_rdata  = vecs[i].mrd;
        imem_resp_ready = vecs[i].irr;
        dmem_resp_ready = vecs[i].drr;
        #2;
        check($sformatf("v%0d mem_req_valid", i), 64'(mem_req_valid), 64'(vecs[i].e_mqv));
        check($sformatf("v%0d imem_req_ready", i), 64'(imem_req_ready), 64'(vecs[i].e_ird));
        check($sformatf("v%0d dmem_req_ready", i), 64'(dmem_req_ready), 64'(vecs[i].e_drd));
        check($sformatf("v%0d imem_resp_valid", i), 64'(imem_resp_valid), 64'(vecs[i].e_irv));
        check($sformatf("v%0d dmem_resp_valid", i), 64'(dmem_resp_valid), 64'(vecs[i].e_drv));
        check($sformatf("v%0d mem_resp_ready", i), 64'(mem_resp_ready), 64'(vecs[i].e_mrr));
        check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
        if (vecs[i].e_mqv) begin
            check($sformatf("v%0d mem_req_addr", i), 64'(mem_req_addr), 64'(vecs[i].e_ma));
            check($sformatf("v%0d mem_req_we", i), 64'(mem_req_we), 64'(vecs[i].e_mwe));
            check($sformatf("v%0d mem_req_wdata", i), 64'(mem_req_wdata), 64'(vecs[i].e_mwd));
            check($sformatf("v%0d mem_req_wstrb", i), 64'(mem_req_wstrb), 64'(vecs[i].e_mws));
        end
        if (vecs[i].e_irv)
            check($sformatf("v%0d imem_resp_data", i), 64'(imem_resp_data), 64'(vecs[i].mrd));
        if (vecs[i].e_drv)
            check($sformatf("v%0d dmem_resp_rdata", i), 64'(dmem_resp_rdata), 64'(vecs[i].mrd));
        next_cycle();
    endtask

    initial begin
        // Fetch stalled by memory for 3 cycles, then accepted.
        vecs[0]  = '{1, 'h10, 0, 0, 'h0, 'h0, 'h0, 0, 0, 'h0, 0, 0,
                     1, 'h10, 0, 'h0, 'h0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = '{1, 'h10, 0, 0, 'h0, 'h0, 'h0, 1, 0, 'h0, 0, 0,
                     1, 'h10, 0, 'h0, 'h0, 1, 0, 0, 0, 0, 0};
        // Fetch response the next cycle.
        vecs[4]  = '{0, 'h0, 0, 0, 'h0, 'h0, 'h0, 0, 1, 'h00513093, 1, 0,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 1, 0, 1, 1};
        vecs[5]  = '{0, 'h0, 0, 0, 'h0, 'h0, 'h0, 0, 0, 'h0, 0, 0,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 0, 0, 0, 0};
        // Both valid: dmem store wins under fixed priority.
        vecs[6]  = '{1, 'h20, 1, 1, 'h1000, 'hDEADBEEF, 'hF, 1, 0, 'h0, 0, 0,
                     1, 'h1000, 1, 'hDEADBEEF, 'hF, 0, 1, 0, 0, 0, 0};
        vecs[7]  = '{1, 'h20, 0, 0, 'h0, 'h0, 'h0, 1, 0, 'h0, 0, 1,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 0, 0, 1, 1};
        vecs[8]  = '{1, 'h20, 0, 0, 'h0, 'h0, 'h0, 1, 1, 'h0, 0, 1,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 0, 1, 1, 1};
        // Waiting fetch issued after the turnaround.
        vecs[9]  = '{1, 'h20, 0, 0, 'h0, 'h0, 'h0, 1, 0, 'h0, 0, 0,
                     1, 'h20, 0, 'h0, 'h0, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 'h0, 0, 0, 'h0, 'h0, 'h0, 0, 1, 'h12345678, 0, 0,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 1, 0, 0, 1};
        vecs[11] = '{0, 'h0, 0, 0, 'h0, 'h0, 'h0, 0, 1, 'h12345678, 1, 0,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 1, 0, 1, 1};
        vecs[12] = '{0, 'h0, 0, 0, 'h0, 'h0, 'h0, 0, 0, 'h0, 0, 0,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 0, 0, 0, 0};
        // Lone dmem load: payload passes through from dmem.
        vecs[13] = '{0, 'h0, 1, 0, 'h2004, 'h55, 'h3, 1, 0, 'h0, 0, 0,
                     1, 'h2004, 0, 'h55, 'h3, 0, 1, 0, 0, 0, 0};
        vecs[14] = '{0, 'h0, 0, 0, 'h0, 'h0, 'h0, 0, 1, 'hCAFEF00D, 0, 1,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 0, 1, 1, 1};
        vecs[15] = '{0, 'h0, 0, 0, 'h0, 'h0, 'h0, 0, 0, 'h0, 0, 0,
                     0, 'h0, 0, 'h0, 'h0, 0, 0, 0, 0, 0, 0};

        // Reset with requests present: everything stays quiet.
        idle_inputs();
        reset_n        = 1'b0;
        imem_req_valid = 1'b1;
        dmem_req_valid = 1'b1;
        mem_req_ready  = 1'b1;
        #12;
        check("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("reset imem_req_ready", 64'(imem_req_ready), 64'd0);
        check("reset dmem_req_ready", 64'(dmem_req_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset state", 64'(state_dbg), 64'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        next_cycle();

        // Table-driven sequences
        for (int i = 0; i < NVEC; i++) apply_vec(i);

        // dmem load with response back-pressure for 5 cycles.
        dmem_req_valid = 1'b1;
        dmem_req_addr  = 32'h3000;
        mem_req_ready  = 1'b1;
        #1;
        check("bp dmem_req_ready", 64'(dmem_req_ready), 64'd1);
        next_cycle();
        dmem_req_valid  = 1'b0;
        imem_req_valid  = 1'b1;
        imem_req_addr   = 32'h44;
        mem_resp_valid  = 1'b1;
        mem_resp_rdata  = 32'hA5A5_0001;
        dmem_resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp%0d mem_resp_ready", c), 64'(mem_resp_ready), 64'd0);
            check($sformatf("bp%0d dmem_resp_valid", c), 64'(dmem_resp_valid), 64'd1);
            check($sformatf("bp%0d state", c), 64'(state_dbg), 64'd1);
            check($sformatf("bp%0d imem_req_ready", c), 64'(imem_req_ready), 64'd0);
            check($sformatf("bp%0d mem_req_valid", c), 64'(mem_req_valid), 64'd0);
            next_cycle();
        end
        dmem_resp_ready = 1'b1;
        #1;
        check("bp release mem_resp_ready", 64'(mem_resp_ready), 64'd1);
        check("bp release rdata", 64'(dmem_resp_rdata), 64'hA5A5_0001);
        next_cycle();
        mem_resp_valid  = 1'b0;
        dmem_resp_ready = 1'b0;
        #1;
        check("bp back idle busy", 64'(busy), 64'd0);
        check("bp next imem_req_ready", 64'(imem_req_ready), 64'd1);
        check("bp next mem_req_addr", 64'(mem_req_addr), 64'h44);
        next_cycle();
        imem_req_valid  = 1'b0;
        mem_resp_valid  = 1'b1;
        imem_resp_ready = 1'b1;
        #1;
        check("bp fetch resp valid", 64'(imem_resp_valid), 64'd1);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Reset while dmem owns an outstanding transaction.
        dmem_req_valid = 1'b1;
        dmem_req_addr  = 32'h5000;
        mem_req_ready  = 1'b1;
        next_cycle();
        dmem_req_valid = 1'b0;
        imem_req_valid = 1'b1;
        imem_req_addr  = 32'h0;
        mem_resp_valid = 1'b1;
        #1;
        check("rst pre dmem_resp_valid", 64'(dmem_resp_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst mid busy", 64'(busy), 64'd0);
        check("rst mid dmem_resp_valid", 64'(dmem_resp_valid), 64'd0);
        check("rst mid mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst mid imem_req_ready", 64'(imem_req_ready), 64'd0);
        next_cycle();
        reset_n        = 1'b1;
        mem_resp_valid = 1'b0;
        #1;
        check("rst after mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("rst after mem_req_addr", 64'(mem_req_addr), 64'h0);
        check("rst after imem_req_ready", 64'(imem_req_ready), 64'd1);
        next_cycle();
        check("rst after busy", 64'(busy), 64'd1);
        imem_req_valid  = 1'b0;
        mem_resp_valid  = 1'b1;
        imem_resp_ready = 1'b1;
        next_cycle();
        idle_inputs();
        next_cycle();

`ifdef MEM_ARB_RR_EN
        // Both held valid: grants must alternate between requesters.
        begin
            logic prev_grant;
            logic grant;
            prev_grant = 1'b0;
            imem_req_valid  = 1'b1;
            imem_req_addr   = 32'h40;
            dmem_req_valid  = 1'b1;
            dmem_req_addr   = 32'h4000;
            mem_req_ready   = 1'b1;
            imem_resp_ready = 1'b1;
            dmem_resp_ready = 1'b1;
            for (int t = 0; t < 8; t++) begin
                #1;
                check($sformatf("rr%0d one grant", t), 64'(imem_req_ready ^ dmem_req_ready), 64'd1);
                grant = dmem_req_ready;
                if (t > 0) check($sformatf("rr%0d alternate", t), 64'(grant), 64'(~prev_grant));
                prev_grant = grant;
                next_cycle();
                mem_resp_valid = 1'b1;
                next_cycle();
                mem_resp_valid = 1'b0;
            end
            idle_inputs();
            next_cycle();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
